// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm clock controller. Stores an alarm time, compares it with
// the running clock, rings with a 1 Hz beep, supports a limited number of
// snoozes and auto-silences after a fixed ring duration.
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [7:0] seconds,
    input  logic [7:0] minutes,
    input  logic [7:0] hours,
    input  logic       alarm_en,
    input  logic       set_alarm,
    input  logic       set_min,
    input  logic       set_hour,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] alarm_min,
    output logic [7:0] alarm_hour,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    // Counter widths grow with the parameters but never drop below the minimums.
    localparam int RING_W = ($clog2(RING_SECS + 1) > 6) ? $clog2(RING_SECS + 1) : 6;
    localparam int SNZ_W  = ($clog2(SNOOZE_SECS + 1) > 9) ? $clog2(SNOOZE_SECS + 1) : 9;
    localparam int SCNT_W = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2;

    localparam logic [RING_W-1:0] RING_LIM = RING_W'(RING_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD = SNZ_W'(SNOOZE_SECS);
    localparam logic [SCNT_W-1:0] SCNT_LIM = SCNT_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          alarm_min_reg, alarm_min_next;
    logic [7:0]          alarm_hour_reg, alarm_hour_next;
    logic [RING_W-1:0]   ring_cnt_reg, ring_cnt_next;
    logic [SNZ_W-1:0]    snz_cnt_reg, snz_cnt_next;
    logic [SCNT_W-1:0]   snooze_cnt_reg, snooze_cnt_next;
    logic                beep_reg, beep_next;
    logic                match_d_reg;
    logic                match;
    logic                trigger;
    logic [RING_W-1:0]   ring_inc;

    // Alarm fires only on the rising edge of the per-second match, so a stop
    // during the matching second cannot re-trigger.
    assign match   = (hours == alarm_hour_reg) && (minutes == alarm_min_reg) && (seconds == 8'd0);
    assign trigger = match && !match_d_reg;

    // Saturating ring-duration increment.
    assign ring_inc = (ring_cnt_reg == '1) ? ring_cnt_reg : ring_cnt_reg + RING_W'(1);

    // State and datapath registers; match_d resets high to suppress a false
    // trigger when reset releases exactly at the alarm time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            alarm_min_reg  <= 8'd0;
            alarm_hour_reg <= 8'd6;
            ring_cnt_reg   <= '0;
            snz_cnt_reg    <= '0;
            snooze_cnt_reg <= '0;
            beep_reg       <= 1'b0;
            match_d_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            alarm_min_reg  <= alarm_min_next;
            alarm_hour_reg <= alarm_hour_next;
            ring_cnt_reg   <= ring_cnt_next;
            snz_cnt_reg    <= snz_cnt_next;
            snooze_cnt_reg <= snooze_cnt_next;
            beep_reg       <= beep_next;
            match_d_reg    <= match;
        end
    end

    // Next-state and counter logic; set mode or disarm overrides everything.
    always_comb begin
        state_next      = state_reg;
        alarm_min_next  = alarm_min_reg;
        alarm_hour_next = alarm_hour_reg;
        ring_cnt_next   = ring_cnt_reg;
        snz_cnt_next    = snz_cnt_reg;
        snooze_cnt_next = snooze_cnt_reg;
        beep_next       = beep_reg;

        if (set_alarm && set_min)
            alarm_min_next = (alarm_min_reg >= 8'd59) ? 8'd0 : alarm_min_reg + 8'd1;
        if (set_alarm && set_hour)
            alarm_hour_next = (alarm_hour_reg >= 8'd23) ? 8'd0 : alarm_hour_reg + 8'd1;

        if (set_alarm || !alarm_en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next      = ARMED;
                    snooze_cnt_next = '0;
                end
                ARMED: begin
                    if (trigger) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                        beep_next     = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_next      = ARMED;
                        snooze_cnt_next = '0;
                    end else if (snooze && (snooze_cnt_reg < SCNT_LIM)) begin
                        state_next      = SNOOZE;
                        snooze_cnt_next = snooze_cnt_reg + SCNT_W'(1);
                        snz_cnt_next    = SNZ_LOAD;
                    end else if (tick_1hz) begin
                        ring_cnt_next = ring_inc;
                        beep_next     = !beep_reg;
                        if (ring_inc >= RING_LIM) begin
                            state_next      = ARMED;
                            snooze_cnt_next = '0;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_next      = ARMED;
                        snooze_cnt_next = '0;
                    end else if (tick_1hz) begin
                        snz_cnt_next = (snz_cnt_reg == '0) ? snz_cnt_reg : snz_cnt_reg - SNZ_W'(1);
                        if (snz_cnt_reg <= SNZ_W'(1)) begin
                            state_next    = RINGING;
                            ring_cnt_next = '0;
                            beep_next     = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are registers or direct decodes of them.
    assign alarm_min  = alarm_min_reg;
    assign alarm_hour = alarm_hour_reg;
    assign ringing    = (state_reg == RINGING);
    assign snoozing   = (state_reg == SNOOZE);
    assign buzzer     = (state_reg == RINGING) && beep_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed checks of alarm_ctrl set mode, ringing, snooze,
// stop, mode override and asynchronous reset.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz, alarm_en, set_alarm, set_min, set_hour, snooze, stop;
    logic [7:0] seconds, minutes, hours;
    logic [7:0] alarm_min, alarm_hour;
    logic       ringing, snoozing, buzzer;

    int nvec = 0;
    int nerr = 0;

    alarm_ctrl #(.RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .alarm_en(alarm_en), .set_alarm(set_alarm), .set_min(set_min),
        .set_hour(set_hour), .snooze(snooze), .stop(stop),
        .alarm_min(alarm_min), .alarm_hour(alarm_hour),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, then settle 1 time unit past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 8'(h);
        minutes = 8'(m);
        seconds = 8'(s);
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    endtask

    task automatic pulse_min();
        set_min = 1'b1; cyc(); set_min = 1'b0;
    endtask

    task automatic pulse_hour();
        set_hour = 1'b1; cyc(); set_hour = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1; cyc(); snooze = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {tick_1hz, set_alarm, set_min, set_hour, snooze, stop} = '0;
        alarm_en = 1'b1;
        set_time(6, 0, 0);
        cyc(); cyc();

        // Reset values
        chk("rst_alarm_hour", 32'(alarm_hour), 32'd6);
        chk("rst_alarm_min",  32'(alarm_min),  32'd0);
        chk("rst_ringing",    32'(ringing),    32'd0);
        chk("rst_snoozing",   32'(snoozing),   32'd0);
        chk("rst_buzzer",     32'(buzzer),     32'd0);

        // Release at exactly 06:00:00: no trigger until match falls
        reset = 1'b0;
        cyc(); cyc(); cyc();
        chk("no_ring_at_release", 32'(ringing), 32'd0);

        // Set-mode wrap of minutes
        set_alarm = 1'b1;
        for (int i = 0; i < 59; i++) pulse_min();
        chk("min_59", 32'(alarm_min), 32'd59);
        pulse_min();
        chk("min_wrap", 32'(alarm_min), 32'd0);

        // Hours wrap from 6: 17 pulses -> 23, 18th -> 0
        for (int i = 0; i < 17; i++) pulse_hour();
        chk("hour_23", 32'(alarm_hour), 32'd23);
        pulse_hour();
        chk("hour_wrap", 32'(alarm_hour), 32'd0);

        // Simultaneous min and hour
        set_min = 1'b1; set_hour = 1'b1; cyc(); set_min = 1'b0; set_hour = 1'b0;
        chk("both_min",  32'(alarm_min),  32'd1);
        chk("both_hour", 32'(alarm_hour), 32'd1);

        // Restore alarm to 06:00
        for (int i = 0; i < 5; i++) pulse_hour();
        for (int i = 0; i < 59; i++) pulse_min();
        chk("restore_hour", 32'(alarm_hour), 32'd6);
        chk("restore_min",  32'(alarm_min),  32'd0);

        // Set pulses ignored outside set mode
        set_alarm = 1'b0;
        pulse_min();
        pulse_hour();
        chk("ignore_min",  32'(alarm_min),  32'd0);
        chk("ignore_hour", 32'(alarm_hour), 32'd6);

        // Ring and auto-silence
        set_time(5, 59, 59);
        cyc(); cyc();
        set_time(6, 0, 0);
        cyc();
        chk("ring_start",   32'(ringing), 32'd1);
        chk("buzz_start",   32'(buzzer),  32'd1);
        set_time(6, 0, 1);
        do_tick();
        chk("buzz_tick1",   32'(buzzer),  32'd0);
        do_tick();
        chk("buzz_tick2",   32'(buzzer),  32'd1);
        for (int i = 0; i < 57; i++) do_tick();
        chk("ring_tick59",  32'(ringing), 32'd1);
        do_tick();
        chk("ring_tick60",  32'(ringing), 32'd0);
        chk("buzz_tick60",  32'(buzzer),  32'd0);

        // Snooze three times, fourth ignored
        set_time(5, 59, 59);
        cyc();
        set_time(6, 0, 0);
        cyc();
        chk("ring_again", 32'(ringing), 32'd1);
        set_time(6, 0, 1);
        for (int n = 1; n <= 3; n++) begin
            pulse_snooze();
            chk($sformatf("snz%0d_enter", n), 32'(snoozing), 32'd1);
            chk($sformatf("snz%0d_buzz", n),  32'(buzzer),   32'd0);
            for (int i = 0; i < 299; i++) do_tick();
            chk($sformatf("snz%0d_t299", n),  32'(snoozing), 32'd1);
            do_tick();
            chk($sformatf("snz%0d_t300", n),  32'(ringing),  32'd1);
            chk($sformatf("snz%0d_buzz300", n), 32'(buzzer), 32'd1);
        end
        pulse_snooze();
        chk("snz4_ringing",  32'(ringing),  32'd1);
        chk("snz4_snoozing", 32'(snoozing), 32'd0);

        // Stop, then stop during the matching second
        pulse_stop();
        chk("stop_ring", 32'(ringing), 32'd0);
        set_time(5, 59, 59);
        cyc();
        set_time(6, 0, 0);
        cyc();
        chk("ring_stoptest", 32'(ringing), 32'd1);
        pulse_stop();
        chk("stop_same_sec", 32'(ringing), 32'd0);
        cyc(); cyc(); cyc();
        chk("no_rering", 32'(ringing), 32'd0);
        set_time(5, 59, 59);
        cyc();
        set_time(6, 0, 0);
        cyc();
        chk("next_day_ring", 32'(ringing), 32'd1);

        // Set mode during SNOOZE forces IDLE
        set_time(6, 0, 1);
        pulse_snooze();
        chk("ovr_snoozing", 32'(snoozing), 32'd1);
        set_alarm = 1'b1;
        cyc();
        chk("ovr_snoozing_off", 32'(snoozing), 32'd0);
        chk("ovr_buzzer",       32'(buzzer),   32'd0);
        chk("ovr_ringing",      32'(ringing),  32'd0);

        // Move alarm to 06:01 and ring
        pulse_min();
        chk("alarm_min_1", 32'(alarm_min), 32'd1);
        set_alarm = 1'b0;
        set_time(6, 0, 59);
        cyc(); cyc();
        set_time(6, 1, 0);
        cyc();
        chk("ring_0601", 32'(ringing), 32'd1);
        chk("buzz_0601", 32'(buzzer),  32'd1);

        // Async reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ringing",    32'(ringing),    32'd0);
        chk("arst_buzzer",     32'(buzzer),     32'd0);
        chk("arst_snoozing",   32'(snoozing),   32'd0);
        chk("arst_alarm_min",  32'(alarm_min),  32'd0);
        chk("arst_alarm_hour", 32'(alarm_hour), 32'd6);
        cyc();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  RING_SECS    60   ring duration in seconds before auto-silence
  SNOOZE_SECS  300  snooze duration in seconds
  MAX_SNOOZE   3    maximum snoozes per alarm event
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk        in   1  system clock; all state changes on rising edge
  reset      in   1  asynchronous, active-high reset
  tick_1hz   in   1  one-clk-wide pulse, once per second
  seconds    in   8  current time, binary 0-59
  minutes    in   8  current time, binary 0-59
  hours      in   8  current time, binary 0-23
  alarm_en   in   1  level; 1 = alarm armed
  set_alarm  in   1  level; 1 = alarm-set mode
  set_min    in   1  one-clk pulse; increment alarm minute
  set_hour   in   1  one-clk pulse; increment alarm hour
  snooze     in   1  one-clk pulse; request snooze
  stop       in   1  one-clk pulse; silence alarm
  alarm_min  out  8  stored alarm minute, 0-59
  alarm_hour out  8  stored alarm hour, 0-23
  ringing    out  1  1 while in RINGING
  snoozing   out  1  1 while in SNOOZE
  buzzer     out  1  beep output

Function
REQ-003 The block SHALL be one clock domain (clk) with an asynchronous, active-high reset (reset).
REQ-004 The FSM SHALL have the states IDLE, ARMED, RINGING and SNOOZE. ringing and snoozing SHALL decode the state register directly.
REQ-005 When set_alarm=1, set_min SHALL increment alarm_min modulo 60 (59->0) and set_hour SHALL increment alarm_hour modulo 24 (23->0). Both SHALL be ignored when set_alarm=0. Simultaneous set_min and set_hour SHALL update both fields in the same cycle.
REQ-006 match SHALL be defined as (hours==alarm_hour && minutes==alarm_min && seconds==0). match_d SHALL be match registered every cycle. The trigger SHALL be defined as match && !match_d.
REQ-007 In any state, set_alarm=1 or alarm_en=0 SHALL force IDLE on the next edge. This rule SHALL have the highest priority.
REQ-008 IDLE SHALL go to ARMED when alarm_en=1 and set_alarm=0. Entering ARMED SHALL clear snooze_cnt.
REQ-009 ARMED SHALL go to RINGING on the trigger. On entry to RINGING, ring_cnt SHALL be cleared and beep SHALL be set to 1.
REQ-010 RINGING SHALL resolve in priority order stop > snooze > timeout:
  - stop: go to ARMED.
  - snooze with snooze_cnt<MAX_SNOOZE: go to SNOOZE, increment snooze_cnt, load snz_cnt=SNOOZE_SECS.
  - snooze with snooze_cnt==MAX_SNOOZE: ignored; remain in RINGING.
  - timeout: each tick_1hz increments ring_cnt; the tick on which ring_cnt reaches RING_SECS SHALL go to ARMED.
REQ-011 In SNOOZE, stop SHALL go to ARMED. Each tick_1hz SHALL decrement snz_cnt. The tick on which snz_cnt reaches 0 SHALL go to RINGING with the REQ-009 entry actions.
REQ-012 In RINGING, beep SHALL toggle on each tick_1hz, and buzzer SHALL equal ringing && beep. buzzer SHALL be 0 in every other state.
REQ-013 A stop pulse in ARMED SHALL NOT re-trigger during the same matching second, because match_d stays 1 until match drops.
REQ-014 ring_cnt SHALL be at least 6 bits wide, snz_cnt at least 9 bits, and snooze_cnt at least 2 bits. All counters SHALL saturate rather than wrap.
REQ-015 All outputs SHALL be registered or a direct decode of registers. There SHALL be no combinational path from inputs to outputs.

Reset
REQ-016 While reset=1, the block SHALL hold: state=IDLE, alarm_hour=6, alarm_min=0, ring_cnt=0, snz_cnt=0, snooze_cnt=0, beep=0, match_d=1, ringing=0, snoozing=0, buzzer=0.
REQ-017 Reset asserted mid-RINGING or mid-SNOOZE SHALL immediately drive all outputs to the REQ-016 values.
REQ-018 Because match_d resets to 1, a time equal to 06:00:00 at reset release SHALL NOT trigger until match has first fallen.

Verification
REQ-019 Set-mode wrap: set_alarm=1 with 60 set_min pulses -> alarm_min back to 0. 18 set_hour pulses from reset -> alarm_hour=0.
REQ-020 Ring and auto-silence: alarm_en=1, time steps 05:59:59 -> 06:00:00 -> ringing=1 on the next edge and buzzer=1. After 60 tick_1hz pulses -> ARMED, ringing=0.
REQ-021 Snooze: while ringing, a snooze pulse -> snoozing=1. After 300 ticks -> ringing=1 again. A 4th snooze request -> ignored, ringing stays 1.
REQ-022 Stop: stop pulse while time is still 06:00:00 -> ARMED, no re-ring within that second. The next day at 06:00:00 -> rings.
REQ-023 Mode override: set_alarm=1 during SNOOZE -> IDLE next edge, snoozing=0, buzzer=0.
REQ-024 Async reset asserted mid-RINGING, between clock edges -> ringing=0 and buzzer=0 before the next edge. All outputs at REQ-016 values.
